// File: rtl/md_pkg.sv
// Shared decode constants and FSM state type for the multiply/divide unit.
package md_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  function automatic logic isMdFunct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negation: magnitude extraction on operand latch
// and sign restoration of results.
module md_signfix #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] value,
  input  logic                negate,
  output logic        [W-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign fixup cycle.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import md_pkg::*;

  md_state_t state, stateNext;

  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mulAcc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     remReg;
  logic [WIDTH-1:0]     dsor;
  logic                 resNeg;
  logic                 remNeg;
  logic                 divZero;
  logic                 opIsDiv;

  logic mdOp, accept, isMul, isDiv, isSigned, isMfhi, isMflo, isMthi, isMtlo;
  logic lastStep;
  logic [CNT_W-1:0] cntInc;

  logic [WIDTH-1:0]   magA, magB;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] partRem;
  logic [WIDTH:0] remDiff;
  logic           remGe;

  assign mdOp     = op_valid && (Opcode == OP_RTYPE) && isMdFunct(Funct);
  assign isMul    = (Funct == F_MULT) || (Funct == F_MULTU);
  assign isDiv    = (Funct == F_DIV)  || (Funct == F_DIVU);
  assign isSigned = (Funct == F_MULT) || (Funct == F_DIV);
  assign isMfhi   = Funct == F_MFHI;
  assign isMflo   = Funct == F_MFLO;
  assign isMthi   = Funct == F_MTHI;
  assign isMtlo   = Funct == F_MTLO;

  assign busy   = state != IDLE;
  assign accept = rst_n && mdOp && !busy && !abort;
  assign stall  = rst_n && mdOp && busy;

  assign rd_valid = accept && (isMfhi || isMflo);
  assign rd_data  = !accept ? '0 : isMfhi ? hi : isMflo ? lo : '0;

  assign lastStep = cnt == CNT_W'(WIDTH - 1);
  assign cntInc   = (cnt == CNT_W'(WIDTH)) ? cnt : cnt + CNT_W'(1);

  md_signfix #(.W(WIDTH)) uMagA (
    .value (src_a),
    .negate(isSigned && src_a[WIDTH-1]),
    .result(magA)
  );

  md_signfix #(.W(WIDTH)) uMagB (
    .value (src_b),
    .negate(isSigned && src_b[WIDTH-1]),
    .result(magB)
  );

  md_signfix #(.W(2*WIDTH)) uProdFix (
    .value (mulAcc),
    .negate(resNeg),
    .result(prodFix)
  );

  md_signfix #(.W(WIDTH)) uQuoFix (
    .value (quo),
    .negate(resNeg),
    .result(quoFix)
  );

  md_signfix #(.W(WIDTH)) uRemFix (
    .value (remReg),
    .negate(remNeg),
    .result(remFix)
  );

  // Multiplier sits in the low half of the accumulator and shifts out as product bits shift in
  assign mulSum = {1'b0, mulAcc[2*WIDTH-1:WIDTH]} + (mulAcc[0] ? {1'b0, mcand} : '0);

  // Remainder stays below the divisor, so the top difference bit alone flags a failed trial
  assign partRem = {remReg, quo[WIDTH-1]};
  assign remDiff = partRem - {1'b0, dsor};
  assign remGe   = !remDiff[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && isMul) begin
          stateNext = MUL;
        end else if (accept && isDiv) begin
          stateNext = DIV;
        end
      end
      MUL:     if (lastStep) stateNext = FIX;
      DIV:     if (lastStep) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (accept && (isMul || isDiv)) cnt <= '0;
          if (accept && isMthi) hi <= src_a;
          if (accept && isMtlo) lo <= src_a;
        end
        MUL, DIV: cnt <= cntInc;
        FIX: begin
          if (opIsDiv) begin
            hi <= remFix;
            lo <= divZero ? '1 : quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept && isMul) begin
          mulAcc  <= {{WIDTH{1'b0}}, magB};
          mcand   <= magA;
          resNeg  <= isSigned && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          opIsDiv <= 1'b0;
        end
        if (accept && isDiv) begin
          remReg  <= '0;
          quo     <= magA;
          dsor    <= magB;
          resNeg  <= isSigned && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          remNeg  <= isSigned && src_a[WIDTH-1];
          divZero <= src_b == '0;
          opIsDiv <= 1'b1;
        end
      end
      MUL: mulAcc <= {mulSum, mulAcc[WIDTH-1:1]};
      DIV: begin
        remReg <= remGe ? remDiff[WIDTH-1:0] : partRem[WIDTH-1:0];
        quo    <= {quo[WIDTH-2:0], remGe};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at WIDTH=32: latency, multiply/divide results,
// corner divides, HI/LO moves, stall, abort and mid-operation reset.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [5:0]   Opcode = 6'd0;
  logic [5:0]   Funct = 6'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         abort = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;

  md_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op_valid(op_valid),
    .Opcode  (Opcode),
    .Funct   (Funct),
    .src_a   (src_a),
    .src_b   (src_b),
    .abort   (abort),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1;
    Opcode   = OP_RTYPE;
    Funct    = f;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic clearIn();
    op_valid = 1'b0;
    Opcode   = 6'd0;
    Funct    = 6'd0;
    src_a    = '0;
    src_b    = '0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic runOp(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int n);
    present(f, a, b);
    step();
    clearIn();
    countBusy(n);
  endtask

  int n;
  int bad;

  initial begin
    // reset held with an mfhi on the bus
    present(F_MFHI, '0, '0);
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_stall", stall, 0);
    step();
    step();
    rst_n = 1'b1;
    clearIn();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    // signed multiply 7 * -3
    present(F_MULT, 32'd7, -32'sd3);
    #1;
    chk("mult_issue_stall", stall, 0);
    step();
    clearIn();
    countBusy(n);
    chk("mult_busy_cycles", n, 33);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // unsigned multiply with a held mfhi behind it
    present(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    present(F_MFHI, '0, '0);
    #1;
    bad = 0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (stall !== 1'b1) bad++;
      n++;
      step();
    end
    chk("multu_busy_cycles", n, 33);
    chk("multu_stall_missing", bad, 0);
    chk("mfhi_stall_after", stall, 0);
    chk("mfhi_rd_valid", rd_valid, 1);
    chk("mfhi_rd_data", rd_data, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    step();
    clearIn();

    // op with nonzero opcode is ignored
    present(F_MULT, 32'd2, 32'd3);
    Opcode = 6'b000001;
    step();
    clearIn();
    #1;
    chk("bad_opcode_busy", busy, 0);

    // divides
    runOp(F_DIV, -32'sd7, 32'd2, n);
    chk("div_busy_cycles", n, 33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    runOp(F_DIVU, 32'd100, 32'd7, n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    runOp(F_DIVU, 32'd5, 32'd0, n);
    chk("divu0_busy_cycles", n, 33);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd5);
    runOp(F_DIV, -32'sd7, 32'd0, n);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    chk("div0_hi", hi, 32'hFFFFFFF9);
    runOp(F_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    // mthi / mtlo then an aborted divide at iteration 10
    present(F_MTHI, 32'h1234, '0);
    step();
    present(F_MTLO, 32'h5678, '0);
    step();
    clearIn();
    #1;
    chk("mthi_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);
    present(F_DIV, 32'd100, 32'd7);
    step();
    clearIn();
    repeat (10) step();
    chk("abort_mid_busy_before", busy, 1);
    abort = 1'b1;
    present(F_MTHI, 32'hDEAD, '0);
    step();
    abort = 1'b0;
    clearIn();
    #1;
    chk("abort_mid_busy", busy, 0);
    chk("abort_mid_hi", hi, 32'h1234);
    chk("abort_mid_lo", lo, 32'h5678);

    // abort landing on the FIX cycle
    present(F_DIV, 32'd100, 32'd7);
    step();
    clearIn();
    repeat (32) step();
    chk("abort_fix_busy_before", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    chk("abort_fix_busy", busy, 0);
    chk("abort_fix_hi", hi, 32'h1234);
    chk("abort_fix_lo", lo, 32'h5678);

    // abort suppresses an mfhi in the same cycle
    abort = 1'b1;
    present(F_MFHI, '0, '0);
    #1;
    chk("abort_mfhi_rd_valid", rd_valid, 0);
    step();
    abort = 1'b0;
    clearIn();

    // reset during MUL
    present(F_MULT, 32'd3, 32'd5);
    step();
    clearIn();
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);

    // mtlo then mflo, then a non-MD funct
    present(F_MTLO, 32'hA5A5, '0);
    step();
    present(F_MFLO, '0, '0);
    #1;
    chk("mflo_rd_valid", rd_valid, 1);
    chk("mflo_rd_data", rd_data, 32'hA5A5);
    step();
    present(6'b100000, 32'd9, 32'd9);
    #1;
    chk("add_rd_valid", rd_valid, 0);
    chk("add_rd_data", rd_data, 0);
    step();
    clearIn();
    #1;
    chk("add_busy", busy, 0);
    chk("add_hi", hi, 0);
    chk("add_lo", lo, 32'hA5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
